// File: rtl/cpu_wb_pkg.sv
// Shared types for the register-file write-back arbiter: request bundle and winner select.
package cpu_wb_pkg;

   localparam int WB_NUM_REGS   = 32;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_RD_W       = $clog2(WB_NUM_REGS);

   typedef struct packed {
      logic                     valid;
      logic [WB_RD_W-1:0]       rd;
      logic [WB_DATA_WIDTH-1:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WIN_NONE   = 2'd0,
      WIN_COMMIT = 2'd1,
      WIN_FIFO   = 2'd2,
      WIN_BYPASS = 2'd3
   } win_sel_e;

endpackage

// File: rtl/cpu_wb_arbiter_if.sv
// Commit/MUL write-back requests in, register-file write port and stall out.
interface cpu_wb_arbiter_if #(
   parameter int RD_W       = 5,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 2
);
   logic                  commit_wb_valid;
   logic [RD_W-1:0]       commit_wb_rd;
   logic [DATA_WIDTH-1:0] commit_wb_data;
   logic                  mul_wb_valid;
   logic [RD_W-1:0]       mul_wb_rd;
   logic [DATA_WIDTH-1:0] mul_wb_data;
   logic                  rf_we;
   logic [RD_W-1:0]       rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;
   logic                  stall;
   logic [CNT_W-1:0]      mul_buf_count;

   modport slave (
      input  commit_wb_valid, commit_wb_rd, commit_wb_data,
      input  mul_wb_valid, mul_wb_rd, mul_wb_data,
      output rf_we, rf_waddr, rf_wdata, stall, mul_buf_count
   );

   modport master (
      output commit_wb_valid, commit_wb_rd, commit_wb_data,
      output mul_wb_valid, mul_wb_rd, mul_wb_data,
      input  rf_we, rf_waddr, rf_wdata, stall, mul_buf_count
   );
endinterface

// File: rtl/cpu_wb_fifo.sv
// Register FIFO holding MUL results that lost arbitration, with a destination-register
// match against every occupied slot for write-after-write ordering.
module cpu_wb_fifo #(
   parameter int DEPTH  = 2,
   parameter int RD_W   = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [RD_W-1:0]   push_rd,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [RD_W-1:0]   head_rd,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full,
   input  logic [RD_W-1:0]   query_rd,
   output logic              rd_match
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [RD_W-1:0]   rd_mem   [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  slot_vld;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         slot_vld <= '0;
      end else begin
         if (pop) begin
            rd_ptr           <= ptr_inc(rd_ptr);
            slot_vld[rd_ptr] <= 1'b0;
         end
         // when full, push and pop hit the same slot; the push must win
         if (push) begin
            wr_ptr           <= ptr_inc(wr_ptr);
            slot_vld[wr_ptr] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]   <= push_rd;
         data_mem[wr_ptr] <= push_data;
      end
   end

   always_comb begin
      rd_match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_vld[i] && (rd_mem[i] == query_rd)) rd_match = 1'b1;
      end
   end

   assign head_rd   = rd_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));

   a_no_overflow : assert property (@(posedge clk) disable iff (reset) !(push && full && !pop))
      else $fatal(1, "cpu_wb_fifo overflow");

endmodule

// File: rtl/cpu_wb_arbiter.sv
// Single register-file write port shared by the commit stage and the non-stallable MUL tail.
module cpu_wb_arbiter
   import cpu_wb_pkg::*;
#(
   parameter int NUM_REGS      = WB_NUM_REGS,
   parameter int DATA_WIDTH    = WB_DATA_WIDTH,
   parameter int MUL_BUF_DEPTH = 2,
   parameter int STARVE_LIMIT  = 3
) (
   input  logic             clk,
   input  logic             reset,
   cpu_wb_arbiter_if.slave  bus
);
   localparam int RD_W  = $clog2(NUM_REGS);
   localparam int CNT_W = $clog2(MUL_BUF_DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   win_sel_e              win;
   logic                  push;
   logic                  pop;
   logic [RD_W-1:0]       head_rd;
   logic [DATA_WIDTH-1:0] head_data;
   logic [CNT_W-1:0]      buf_count;
   logic                  buf_empty;
   logic                  buf_full;
   logic                  rd_match;
   logic [STV_W-1:0]      starve_q;
   logic                  starve_at_limit;
   logic [CNT_W:0]        occ_next;

   cpu_wb_fifo #(
      .DEPTH  (MUL_BUF_DEPTH),
      .RD_W   (RD_W),
      .DATA_W (DATA_WIDTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_rd   (bus.mul_wb_rd),
      .push_data (bus.mul_wb_data),
      .pop       (pop),
      .head_rd   (head_rd),
      .head_data (head_data),
      .count     (buf_count),
      .empty     (buf_empty),
      .full      (buf_full),
      .query_rd  (bus.commit_wb_rd),
      .rd_match  (rd_match)
   );

   assign starve_at_limit = (starve_q == STV_W'(STARVE_LIMIT));

   always_comb begin
      win = WIN_NONE;
      if (reset) begin
         win = WIN_NONE;
      end else if (!buf_empty &&
                   (buf_full || starve_at_limit || (bus.commit_wb_valid && rd_match))) begin
         win = WIN_FIFO;
      end else if (bus.commit_wb_valid) begin
         win = WIN_COMMIT;
      end else if (!buf_empty) begin
         win = WIN_FIFO;
      end else if (bus.mul_wb_valid) begin
         win = WIN_BYPASS;
      end
   end

   always_comb begin
      bus.rf_we    = 1'b0;
      bus.rf_waddr = '0;
      bus.rf_wdata = '0;
      case (win)
         WIN_COMMIT: begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.commit_wb_rd;
            bus.rf_wdata = bus.commit_wb_data;
         end
         WIN_FIFO: begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = head_rd;
            bus.rf_wdata = head_data;
         end
         WIN_BYPASS: begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.mul_wb_rd;
            bus.rf_wdata = bus.mul_wb_data;
         end
         default: ;
      endcase
   end

   assign push              = !reset && bus.mul_wb_valid && (win != WIN_BYPASS);
   assign pop               = (win == WIN_FIFO);
   assign bus.stall         = !reset && bus.commit_wb_valid && (win != WIN_COMMIT);
   assign bus.mul_buf_count = buf_count;
   assign occ_next          = {1'b0, buf_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);

   // counts commit wins against a buffer that is still occupied after this cycle's push
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
      end else if ((win == WIN_FIFO) || (occ_next == '0)) begin
         starve_q <= '0;
      end else if ((win == WIN_COMMIT) && !starve_at_limit) begin
         starve_q <= starve_q + STV_W'(1);
      end
   end

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Scoreboard bench for cpu_wb_arbiter: a queue-based reference model predicts each cycle's
// write port, stall and occupancy; a negedge monitor compares the DUT against it.
module tb_cpu_wb_arbiter;
   import cpu_wb_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 3;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        stall;
      logic [1:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cpu_wb_arbiter_if #(.RD_W(5), .DATA_WIDTH(32), .CNT_W(2)) ifc ();

   cpu_wb_arbiter #(
      .NUM_REGS      (32),
      .DATA_WIDTH    (32),
      .MUL_BUF_DEPTH (DEPTH),
      .STARVE_LIMIT  (LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   exp_t    exp_q[$];
   wb_req_t mq[$];
   int      starve_m = 0;
   bit      last_stall = 1'b0;
   int      checks = 0;
   int      errors = 0;

   logic        r_cv;
   logic [4:0]  r_crd;
   logic [31:0] r_cd;

   // one clock of stimulus; the model's view of the cycle is queued for the monitor
   task automatic cycle(input logic rst_v, input logic cv, input logic [4:0] crd,
                        input logic [31:0] cd, input logic mv, input logic [4:0] mrd,
                        input logic [31:0] md);
      exp_t    e;
      wb_req_t tmp;
      bit      ne;
      bit      match;
      int      w;
      @(posedge clk);
      #1;
      reset               = rst_v;
      ifc.commit_wb_valid = cv;
      ifc.commit_wb_rd    = crd;
      ifc.commit_wb_data  = cd;
      ifc.mul_wb_valid    = mv;
      ifc.mul_wb_rd       = mrd;
      ifc.mul_wb_data     = md;
      e = '0;
      if (rst_v) begin
         mq.delete();
         starve_m   = 0;
         last_stall = 1'b0;
      end else begin
         e.cnt = 2'(mq.size());
         ne    = (mq.size() > 0);
         match = 1'b0;
         foreach (mq[i]) if (cv && mq[i].rd == crd) match = 1'b1;
         // 0 idle, 1 commit, 2 buffered MUL, 3 direct MUL
         if (ne && (mq.size() == DEPTH || starve_m == LIMIT || match)) w = 2;
         else if (cv) w = 1;
         else if (ne) w = 2;
         else if (mv) w = 3;
         else w = 0;
         case (w)
            1: begin e.we = 1'b1; e.addr = crd; e.data = cd; end
            2: begin e.we = 1'b1; e.addr = mq[0].rd; e.data = mq[0].data; end
            3: begin e.we = 1'b1; e.addr = mrd; e.data = md; end
            default: ;
         endcase
         e.stall = cv && (w != 1);
         if (w == 2) tmp = mq.pop_front();
         if (mv && w != 3) mq.push_back({1'b1, mrd, md});
         if (w == 2 || mq.size() == 0) starve_m = 0;
         else if (w == 1 && starve_m < LIMIT) starve_m++;
         last_stall = e.stall;
      end
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      exp_t act;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = {ifc.rf_we, ifc.rf_waddr, ifc.rf_wdata, ifc.stall, ifc.mul_buf_count};
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL wb_cycle t=%0t got we=%0b addr=%0d data=%h stall=%0b cnt=%0d expected we=%0b addr=%0d data=%h stall=%0b cnt=%0d",
                     $time, act.we, act.addr, act.data, act.stall, act.cnt,
                     e.we, e.addr, e.data, e.stall, e.cnt);
         end
      end
   end

   initial begin
      ifc.commit_wb_valid = 1'b0;
      ifc.commit_wb_rd    = '0;
      ifc.commit_wb_data  = '0;
      ifc.mul_wb_valid    = 1'b0;
      ifc.mul_wb_rd       = '0;
      ifc.mul_wb_data     = '0;

      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 5, 32'h1, 1, 6, 32'h2);
      // commit only, then MUL bypass
      cycle(0, 1, 5, 32'hA5A5_0001, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 7, 32'h1234);
      cycle(0, 0, 0, 0, 0, 0, 0);
      // simultaneous: commit wins, MUL drains next idle cycle
      cycle(0, 1, 3, 32'hC0DE_0003, 1, 9, 32'h9999);
      cycle(0, 0, 0, 0, 0, 0, 0);
      // starvation bound
      cycle(0, 1, 10, 32'h10, 1, 20, 32'h2020);
      cycle(0, 1, 11, 32'h11, 0, 0, 0);
      cycle(0, 1, 12, 32'h12, 0, 0, 0);
      cycle(0, 1, 13, 32'h13, 0, 0, 0);
      cycle(0, 1, 13, 32'h13, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      // same destination in buffer and commit
      cycle(0, 1, 1, 32'h1, 1, 4, 32'h4444);
      cycle(0, 1, 4, 32'hC4C4, 0, 0, 0);
      cycle(0, 1, 4, 32'hC4C4, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      // full buffer with push and pop together, then reset mid-stream
      cycle(0, 1, 2, 32'h2, 1, 20, 32'hA0);
      cycle(0, 1, 3, 32'h3, 1, 21, 32'hA1);
      cycle(0, 1, 6, 32'h6, 1, 22, 32'hA2);
      cycle(0, 1, 6, 32'h6, 1, 23, 32'hA3);
      cycle(1, 1, 6, 32'h6, 1, 24, 32'hA4);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 25, 32'hA5);

      r_cv = 1'b0; r_crd = '0; r_cd = '0;
      for (int n = 0; n < 600; n++) begin
         if (!last_stall) begin
            r_cv  = ($urandom_range(0, 99) < 60);
            r_crd = 5'($urandom_range(0, 7));
            r_cd  = $urandom;
         end
         if ($urandom_range(0, 299) == 0)
            cycle(1, r_cv, r_crd, r_cd, 1'b0, 5'd0, 32'd0);
         else
            cycle(0, r_cv, r_crd, r_cd, 1'($urandom_range(0, 99) < 45),
                  5'($urandom_range(0, 7)), $urandom);
      end

      cycle(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      if (checks < 12) begin
         errors++;
         $display("FAIL check_count got %0d expected at least 12", checks);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_wb_arbiter.md
Name: cpu_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order commit stage (ALU and load results) and the tail of the fixed-latency 5-stage MUL pipeline.
- The MUL pipeline cannot stall, so its results enter a small holding FIFO. The commit stage can be held, and is held through `stall`.
- Sits between the commit/MUL tails and the register file. Its `stall` is ORed into the existing hazard-unit stall that freezes fetch through commit.

Parameters:
- NUM_REGS, `NUM_REGS (32): register count; register ID width is $clog2(NUM_REGS).
- DATA_WIDTH, 32: write-data width.
- MUL_BUF_DEPTH, 2: MUL holding FIFO entries; must be ≥1.
- STARVE_LIMIT, 3: consecutive cycles a non-empty FIFO may lose arbitration; must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- commit_wb_valid  in  1  commit stage requests a register write
- commit_wb_rd  in  $clog2(NUM_REGS)  commit destination register
- commit_wb_data  in  DATA_WIDTH  commit write data
- mul_wb_valid  in  1  MUL stage-5 result valid; must be accepted this cycle
- mul_wb_rd  in  $clog2(NUM_REGS)  MUL destination register
- mul_wb_data  in  DATA_WIDTH  MUL result
- rf_we  out  1  register-file write enable
- rf_waddr  out  $clog2(NUM_REGS)  register-file write address
- rf_wdata  out  DATA_WIDTH  register-file write data
- stall  out  1  commit write not taken this cycle; pipeline through commit freezes
- mul_buf_count  out  $clog2(MUL_BUF_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset: FIFO empty, pointers 0, starve counter 0. While reset is high, rf_we=0, rf_waddr=0, rf_wdata=0, stall=0, mul_buf_count=0. Reset mid-operation discards buffered MUL results; there is no write on the reset edge.
- Outputs are combinational from the inputs and state. The register file samples on the rising edge of clk. One write per cycle.
- Per-cycle winner, evaluated in priority order:
  1. FIFO non-empty and any of the following → FIFO head wins:
     - FIFO full, or
     - starve counter == STARVE_LIMIT, or
     - commit_wb_valid and commit_wb_rd matches the rd of any FIFO entry (WAW ordering).
  2. commit_wb_valid → commit wins.
  3. FIFO non-empty → FIFO head wins.
  4. FIFO empty and mul_wb_valid → bypass: the MUL input is written directly with zero latency and is not enqueued.
  5. Otherwise rf_we=0.
- stall = commit_wb_valid && winner != commit. While stalled, the commit stage holds valid/rd/data unchanged until they are taken.
- Enqueue: mul_wb_valid and not bypassed → push. Push and pop in the same cycle are legal, including when the FIFO is full: the head pops because full forces a FIFO win, so overflow is impossible.
- Bypass is never taken when the FIFO is non-empty; this keeps MUL results in order.
- Starve counter:
  - Increments when commit wins and the FIFO is non-empty (after any same-cycle push).
  - Clears when the FIFO head wins, or when the FIFO is empty at end of cycle.
  - Saturates at STARVE_LIMIT.
- mul_buf_count is the registered occupancy, range 0..MUL_BUF_DEPTH. Pointer wrap is modulo MUL_BUF_DEPTH.
- rd = 0 receives no special treatment; it is arbitrated and written like any register.
- Assertion: a push when count == MUL_BUF_DEPTH without a same-cycle pop is a fatal simulation error.

Decomposition:
- Package cpu_wb_pkg holds:
  - typedef wb_req_t, packed {valid, rd, data};
  - the enum for the winner select (WIN_NONE, WIN_COMMIT, WIN_FIFO, WIN_BYPASS).
- Sub-module cpu_wb_fifo:
  - MUL_BUF_DEPTH-entry register FIFO with push/pop, head output and count;
  - plus a combinational rd_match output: a compare of a query rd against all valid entries.
- cpu_wb_arbiter holds the priority logic, the starve counter and the output mux.

Test Plan:
- Commit only, rd=5, data=0xA5A5_0001, FIFO empty → same cycle rf_we=1, waddr=5, wdata=0xA5A5_0001; stall=0.
- MUL only, rd=7, data=0x1234, FIFO empty → bypass, same-cycle write of rd 7; mul_buf_count stays 0.
- Commit rd=3 and MUL rd=9 in the same cycle → commit written in cycle N, MUL enqueued (count=1); next idle cycle writes rd 9 and count returns to 0.
- Commit valid every cycle, MUL pushes one result, STARVE_LIMIT=3 → commit wins 3 cycles; cycle 4 FIFO head written with stall=1; cycle 5 commit resumes.
- FIFO holds rd 4, commit arrives with rd 4 → stall=1 while the head (rd 4) is written; next cycle commit rd 4 is written, so the final register value is the commit data.
- FIFO full (2 entries) and MUL pushes again while commit is valid → head pops, new entry pushes, count stays 2, stall=1, no assertion fires. Then assert reset mid-stream → all outputs 0 and count=0 the cycle after release.
